// File: rtl/abro_pkg.sv
// Shared definitions for the ABRO front end and the state-machine wrapper.
package abro_pkg;

  localparam int ABRO_DEBOUNCE_DEFAULT = 4;

  typedef struct packed {
    logic a;
    logic b;
    logic r;
  } abro_evt_t;

endpackage

// File: rtl/abro_input_conditioner_if.sv
// Raw pad inputs in; debounced levels and single-cycle rise pulses out.
// master: drives the raw inputs (pads/bench); slave: the conditioner.
interface abro_input_conditioner_if;

  logic a_raw;
  logic b_raw;
  logic r_raw;
  logic a_level;
  logic b_level;
  logic r_level;
  logic a_pulse;
  logic b_pulse;
  logic r_pulse;

  modport master (
    output a_raw, b_raw, r_raw,
    input  a_level, b_level, r_level, a_pulse, b_pulse, r_pulse
  );

  modport slave (
    input  a_raw, b_raw, r_raw,
    output a_level, b_level, r_level, a_pulse, b_pulse, r_pulse
  );

endinterface

// File: rtl/abro_debounce_channel.sv
// One input channel: 2-flop synchroniser, saturating debounce counter,
// debounced level and a registered pulse on each accepted 0->1 change.
module abro_debounce_channel
  import abro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = ABRO_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             lvl_q, lvl_d;
  logic             p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any return of s2 to the current level restarts the qualification window.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    p_d   = 1'b0;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      lvl_d = s2_q;
      cnt_d = '0;
      p_d   = s2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
      p_q   <= 1'b0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

  assign level      = lvl_q;
  assign rise_pulse = p_q;

endmodule

// File: rtl/abro_input_conditioner.sv
// Three debounced channels feeding the ABRO FSM; restart masks A/B events
// while it is held or firing, so those events are dropped rather than queued.
module abro_input_conditioner
  import abro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = ABRO_DEBOUNCE_DEFAULT
) (
  input logic                     clk,
  input logic                     reset,
  abro_input_conditioner_if.slave bus
);

  abro_evt_t lvl;
  abro_evt_t rise;

  abro_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_a (
    .clk        (clk),
    .reset      (reset),
    .raw        (bus.a_raw),
    .level      (lvl.a),
    .rise_pulse (rise.a)
  );

  abro_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b (
    .clk        (clk),
    .reset      (reset),
    .raw        (bus.b_raw),
    .level      (lvl.b),
    .rise_pulse (rise.b)
  );

  abro_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_r (
    .clk        (clk),
    .reset      (reset),
    .raw        (bus.r_raw),
    .level      (lvl.r),
    .rise_pulse (rise.r)
  );

  assign bus.a_level = lvl.a;
  assign bus.b_level = lvl.b;
  assign bus.r_level = lvl.r;
  assign bus.a_pulse = rise.a & ~lvl.r & ~rise.r;
  assign bus.b_pulse = rise.b & ~lvl.r & ~rise.r;
  assign bus.r_pulse = rise.r;

endmodule

// File: tb/tb_abro_input_conditioner.sv
// Directed bench for abro_input_conditioner with N = 4.
// Inputs change and outputs are sampled 1 ns after each rising edge; "edge 0"
// is the first edge that samples a newly driven raw value.
module tb_abro_input_conditioner;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   n_hits;
  int   hit_at;

  abro_input_conditioner_if bus ();

  abro_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver helpers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] all_outs();
    return {bus.a_level, bus.b_level, bus.r_level,
            bus.a_pulse, bus.b_pulse, bus.r_pulse};
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.a_raw = 1'b0;
    bus.b_raw = 1'b0;
    bus.r_raw = 1'b0;
    step(3);
    check("rst_outs", 32'(all_outs()), 32'h0);
    reset = 1'b0;
    step(1);
    check("idle_outs", 32'(all_outs()), 32'h0);

    // A held high: level and pulse rise after edge 5, pulse gone after edge 6
    bus.a_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t1_wait", 32'({bus.a_level, bus.a_pulse}), 32'h0);
    end
    step(1);
    check("t1_rise", 32'({bus.a_level, bus.a_pulse}), 32'h3);
    step(1);
    check("t1_drop", 32'({bus.a_level, bus.a_pulse}), 32'h2);
    n_hits = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.a_pulse) n_hits++;
    end
    check("t1_held_pulses", 32'(n_hits), 32'd0);
    bus.a_raw = 1'b0;
    step(7);
    check("t1_release", 32'({bus.a_level, bus.a_pulse}), 32'h0);

    // B high for three samples only: counter climbs to 3, then is cleared
    bus.b_raw = 1'b1;
    step(3);
    bus.b_raw = 1'b0;
    step(2);
    check("t2_cnt_peak", 32'(dut.u_b.cnt_q), 32'd3);
    check("t2_outs_peak", 32'({bus.b_level, bus.b_pulse}), 32'h0);
    step(1);
    check("t2_cnt_clear", 32'(dut.u_b.cnt_q), 32'd0);
    n_hits = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (bus.b_level || bus.b_pulse) n_hits++;
    end
    check("t2_reject", 32'(n_hits), 32'd0);

    // Bounce 1,0,1,0,1 then stable 1: last rise sampled at edge 4, pulse after edge 9
    n_hits = 0;
    hit_at = -1;
    for (int i = 0; i < 15; i++) begin
      bus.a_raw = (i < 4) ? ((i % 2) == 0) : 1'b1;
      step(1);
      if (bus.a_pulse) begin
        n_hits++;
        hit_at = i;
      end
    end
    check("t3_pulse_count", 32'(n_hits), 32'd1);
    check("t3_pulse_edge", 32'(hit_at), 32'd9);
    bus.a_raw = 1'b0;
    step(8);

    // A and B together
    bus.a_raw = 1'b1;
    bus.b_raw = 1'b1;
    step(5);
    check("t4_pre", 32'({bus.a_pulse, bus.b_pulse}), 32'h0);
    step(1);
    check("t4_both", 32'({bus.a_pulse, bus.b_pulse}), 32'h3);
    step(1);
    check("t4_after", 32'({bus.a_pulse, bus.b_pulse}), 32'h0);
    bus.a_raw = 1'b0;
    bus.b_raw = 1'b0;
    step(8);

    // R held: r_pulse once, A qualifies but its pulse is discarded
    bus.r_raw = 1'b1;
    step(6);
    check("t5_r_rise", 32'({bus.r_level, bus.r_pulse}), 32'h3);
    step(1);
    check("t5_r_held", 32'({bus.r_level, bus.r_pulse}), 32'h2);
    bus.a_raw = 1'b1;
    n_hits = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.a_pulse || bus.r_pulse) n_hits++;
    end
    check("t5_a_masked", 32'(n_hits), 32'd0);
    check("t5_a_level", 32'(bus.a_level), 32'd1);
    bus.a_raw = 1'b0;
    bus.r_raw = 1'b0;
    step(8);
    check("t5_idle", 32'(all_outs()), 32'h0);

    // Reset at cnt == 2 aborts the count; full latency after release
    bus.a_raw = 1'b1;
    step(4);
    check("t6_cnt2", 32'(dut.u_a.cnt_q), 32'd2);
    reset = 1'b1;
    step(1);
    check("t6_reset_outs", 32'(all_outs()), 32'h0);
    check("t6_reset_cnt", 32'(dut.u_a.cnt_q), 32'd0);
    reset = 1'b0;
    step(5);
    check("t6_pre", 32'({bus.a_level, bus.a_pulse}), 32'h0);
    step(1);
    check("t6_pulse", 32'({bus.a_level, bus.a_pulse}), 32'h3);
    bus.a_raw = 1'b0;
    step(8);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
